// File: rtl/led_bank_arbiter.sv
// Two-requester LED bank arbiter with minimum dwell and a free-running idle pattern.
// Ownership alternates on ties; the LED output is registered one cycle behind the state.
module led_bank_arbiter #(
    parameter int TICK_DIV    = 12500000,
    parameter int DWELL_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] req_led0,
    input  logic [3:0] req_led1,
    input  logic [1:0] pat_mode,
    output logic [1:0] gnt,
    output logic [3:0] led,
    output logic       busy
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS + 1) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DMAX = DW'(DWELL_TICKS);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    step_q, step_d;
    logic [1:0]    mode_q;
    logic [DW-1:0] dwell_q;
    logic          last_q;
    logic [1:0]    gnt_q;
    logic          busy_q;
    logic [3:0]    led_q;
    logic [3:0]    pat;
    logic          tick;
    logic          dwell_done;

    assign tick       = (presc_q == PMAX);
    assign dwell_done = (dwell_q == DMAX);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        step_d  = step_q;
        if (pat_mode != mode_q)
            step_d = 4'd0;
        else if (tick)
            step_d = step_q + 4'd1;
    end

    // Pattern follows the registered mode so it changes together with the step clear.
    always_comb begin
        pat = 4'b0000;
        case (mode_q)
            2'b00: pat = 4'b0000;
            2'b01: pat = 4'b0001 << step_q[1:0];
            2'b10: pat = {4{step_q[0]}};
            2'b11: pat = step_q;
            default: pat = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req[0] && (!req[1] || last_q))
                    state_d = OWN0;
                else if (req[1])
                    state_d = OWN1;
            end
            OWN0: begin
                if (!req[0])
                    state_d = req[1] ? OWN1 : IDLE;
                else if (req[1] && dwell_done)
                    state_d = OWN1;
            end
            OWN1: begin
                if (!req[1])
                    state_d = req[0] ? OWN0 : IDLE;
                else if (req[0] && dwell_done)
                    state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            step_q  <= 4'd0;
            mode_q  <= pat_mode;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            mode_q  <= pat_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            dwell_q <= '0;
            last_q  <= 1'b1;
            led_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            gnt_q   <= {state_d == OWN1, state_d == OWN0};
            busy_q  <= (state_d != IDLE);
            if (state_d != state_q)
                dwell_q <= '0;
            else if (tick && state_q != IDLE && !dwell_done)
                dwell_q <= dwell_q + 1'b1;
            if (state_d == OWN0 && state_q != OWN0)
                last_q <= 1'b0;
            else if (state_d == OWN1 && state_q != OWN1)
                last_q <= 1'b1;
            case (state_q)
                OWN0:    led_q <= req_led0;
                OWN1:    led_q <= req_led1;
                default: led_q <= pat;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign led  = led_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with TICK_DIV=4, DWELL_TICKS=2.
// Edge En is the n-th rising edge after reset release; ticks land on edges E4, E8, ...
module tb_led_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] req_led0;
    logic [3:0] req_led1;
    logic [1:0] pat_mode;
    logic [1:0] gnt;
    logic [3:0] led;
    logic       busy;

    int total = 0;
    int bad   = 0;

    led_bank_arbiter #(.TICK_DIV(4), .DWELL_TICKS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_led0 (req_led0),
        .req_led1 (req_led1),
        .pat_mode (pat_mode),
        .gnt      (gnt),
        .led      (led),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; req_led0 = 4'h0; req_led1 = 4'h0; pat_mode = 2'b01;

        // running light in idle, reset values first
        do_reset();
        chk("rst_gnt", {2'b00, gnt}, 4'h0);
        chk("rst_led", led, 4'h0);
        chk("rst_busy", {3'b000, busy}, 4'h0);
        for (int k = 0; k < 20; k++) begin
            logic [3:0] e;
            nxt();
            e = 4'b0001 << ((k / 4) % 4);
            chk("run_led", led, e);
            chk("run_gnt", {2'b00, gnt}, 4'h0);
        end

        // tie from reset goes to requester 0, then dwell handover both ways
        pat_mode = 2'b00; req = 2'b11; req_led0 = 4'h5; req_led1 = 4'hA;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            nxt();
            chk("tie_gnt0", {2'b00, gnt}, 4'h1);
            if (k == 1) chk("tie_led_idle", led, 4'h0);
            if (k == 1) chk("tie_busy", {3'b000, busy}, 4'h1);
            if (k >= 2) chk("tie_led0", led, 4'h5);
        end
        nxt();
        chk("hand_gnt1", {2'b00, gnt}, 4'h2);
        chk("hand_busy", {3'b000, busy}, 4'h1);
        nxt();
        chk("hand_led1", led, 4'hA);
        for (int k = 11; k <= 16; k++) begin
            nxt();
            chk("hold_gnt1", {2'b00, gnt}, 4'h2);
        end
        nxt();
        chk("back_gnt0", {2'b00, gnt}, 4'h1);

        // owner drops, bank returns to pattern, next tie goes to requester 1
        pat_mode = 2'b01; req = 2'b01; req_led0 = 4'h3;
        do_reset();
        nxt();
        chk("own0_gnt", {2'b00, gnt}, 4'h1);
        nxt();
        chk("own0_led", led, 4'h3);
        req = 2'b00;
        nxt();
        chk("drop_gnt", {2'b00, gnt}, 4'h0);
        chk("drop_busy", {3'b000, busy}, 4'h0);
        chk("drop_led", led, 4'h3);
        nxt();
        chk("drop_pat", led, 4'h1);
        req = 2'b11;
        nxt();
        chk("tie_last0", {2'b00, gnt}, 4'h2);
        chk("tie_last0_led", led, 4'h2);

        // lone requester 1 holds indefinitely, then handover with saturated and fresh dwell
        pat_mode = 2'b00; req = 2'b10; req_led1 = 4'hC;
        do_reset();
        for (int k = 1; k <= 81; k++) begin
            nxt();
            if (k % 8 == 1) chk("lone_gnt1", {2'b00, gnt}, 4'h2);
            if (k == 2) chk("lone_led1", led, 4'hC);
        end
        req = 2'b11;
        nxt();
        chk("sat_hand", {2'b00, gnt}, 4'h1);
        for (int k = 83; k <= 88; k++) begin
            nxt();
            chk("wait_dwell", {2'b00, gnt}, 4'h1);
        end
        nxt();
        chk("dwell_hand", {2'b00, gnt}, 4'h2);

        // mode change 11 -> 10 at step 7 clears the step
        pat_mode = 2'b11; req = 2'b00;
        do_reset();
        repeat (29) nxt();
        chk("cnt_step7", led, 4'h7);
        pat_mode = 2'b10;
        nxt();
        chk("mode_chg", led, 4'h7);
        for (int k = 31; k <= 37; k++) begin
            logic [3:0] e;
            nxt();
            e = (k >= 33 && k <= 36) ? 4'hF : 4'h0;
            chk("blink_led", led, e);
        end

        // reset pulse during ownership, pending tie restarts at requester 0
        pat_mode = 2'b00; req = 2'b10; req_led1 = 4'hA;
        do_reset();
        nxt();
        nxt();
        chk("pre_gnt1", {2'b00, gnt}, 4'h2);
        chk("pre_led", led, 4'hA);
        rst = 1'b1; req = 2'b11;
        nxt();
        chk("mid_rst_gnt", {2'b00, gnt}, 4'h0);
        chk("mid_rst_led", led, 4'h0);
        chk("mid_rst_busy", {3'b000, busy}, 4'h0);
        rst = 1'b0;
        nxt();
        chk("post_rst_gnt", {2'b00, gnt}, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
